uart_rom_loader: RTL
====================

# uart_rom_loader

Receives a Hack program over a UART serial line, assembles 16-bit instructions, and writes them into `hack_soc` ROM through its ROM-loading port (`rom_loader_load`, `rom_loader_sck`, `rom_loader_data`, `rom_loader_ack`). It sits directly upstream of `hack_soc` in the FPGA top and replaces the file-based loader when the program is delivered from a host PC. `done_loading` tells the top when to release `hack_external_reset`.

## Interface
- `CLKS_PER_BIT`, 104: clock cycles per UART bit, with a minimum of 4.
- `DATA_WIDTH`, 16: instruction width. This block supports 16 only.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset. Clears all state.
- `run` input 1: level signal. While high, the block accepts a new load session when in IDLE.
- `uart_rx` input 1: asynchronous serial input, 8N1, LSB first, idles high.
- `rom_loader_load` output 1: high for the whole session, from the first data word until DONE or ERROR.
- `rom_loader_sck` output 1: write strobe for the four-phase handshake.
- `rom_loader_data` output 16: instruction word. Held stable while `rom_loader_sck` is high.
- `rom_loader_ack` input 1: handshake acknowledge from `hack_soc`.
- `done_loading` output 1: level signal, high in DONE.
- `error` output 1: level signal, high in ERROR.
- `word_count` output 16: number of words written so far in this session.

## Operation
- **Session frame:** `LEN_HI, LEN_LO`, then N × `(W_HI, W_LO)`, then optionally `CS_HI, CS_LO`. All fields are big-endian.
- **UART receiver:**
  - `uart_rx` passes through a 2-flop synchronizer.
  - A falling edge starts a byte. The start bit is re-checked at `CLKS_PER_BIT/2`; if it is high, the receiver ignores it and returns to idle.
  - Data bits are sampled at bit centres.
  - The stop bit must be 1, otherwise the receiver raises a framing error.
  - `rx_valid` pulses for 1 cycle per byte.
- **Byte buffer:** a 1-byte holding register sits between the receiver and the FSM.
  - The FSM consumes the byte when it is in a byte-consuming state.
  - A new byte arriving while the register is still full is an overrun error.
- **FSM states:** IDLE, LEN_HI, LEN_LO, W_HI, W_LO, SCK_H, SCK_L, CS_HI, CS_LO, DONE, ERROR.
- **Transitions:**
  - IDLE→LEN_HI when `run`=1.
  - LEN_HI→LEN_LO on a byte.
  - LEN_LO→W_HI on a byte if N≠0. If N=0, go to CS_HI when the macro is defined, otherwise DONE.
  - W_HI→W_LO on a byte.
  - W_LO→SCK_H on a byte. This loads `rom_loader_data` and raises `rom_loader_sck` and `rom_loader_load`.
  - SCK_H→SCK_L when `rom_loader_ack`=1. `rom_loader_sck` drops.
  - SCK_L, when `rom_loader_ack`=0: increment `word_count`, then go to W_HI if words remain, else CS_HI (macro defined) or DONE.
- **Exit states:**
  - DONE: `rom_loader_load`=0 and `done_loading`=1. Stays in DONE until `run`=0, then returns to IDLE and clears `word_count`.
  - ERROR is sticky until `reset`. In ERROR, `rom_loader_load`=0 and `rom_loader_sck`=0.
- **Error sources:** framing error, overrun, or checksum mismatch. A framing error while in IDLE is ignored.
- **Bytes outside a session:** bytes received in IDLE, DONE or ERROR are discarded.

## Timing
- **Reset values:**
  - `rom_loader_load`, `rom_loader_sck`, `done_loading`, `error` = 0.
  - `rom_loader_data` = 0 and `word_count` = 0.
  - FSM in IDLE, byte buffer empty.
- **Receiver latency:** `rx_valid` asserts `CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 2` cycles after the start-bit falling edge reaches `uart_rx`.
- **Byte consumption:** the FSM consumes a buffered byte on the cycle after `rx_valid`.
- **Write strobe:** `rom_loader_sck` rises 1 cycle after the W_LO byte is consumed.
- **Handshake:** each ack edge is registered, so the FSM responds 1 cycle after it.
  - `rom_loader_data` never changes while `rom_loader_sck` is high or while `rom_loader_ack` is high.
  - The handshake has no timeout. A stalled ack only risks an overrun; that is the host's responsibility.
- **Outputs:** all outputs are registered.
- **Reset mid-session:** `rom_loader_sck` and `rom_loader_load` drop asynchronously and the partial load is abandoned.

## Configuration
- `UART_ROM_LOADER_CHECKSUM_EN`
  - **Defined:** the FSM runs CS_HI→CS_LO after the last word. The received 16-bit value must equal the sum of all data words mod 2^16 (N=0 gives sum 0). Match goes to DONE; mismatch goes to ERROR. `done_loading` is asserted only after the checksum is verified; all words have already been written to ROM.
  - **Undefined:** no checksum bytes are expected, the accumulator is not built, and the FSM goes straight to DONE after the last handshake.

## Test plan
- **Basic load:** `CLKS_PER_BIT`=8, `run`=1, send `00 02 12 34 AB CD` with a bench ack responder of 3-cycle latency. Required: two handshakes with `rom_loader_data` 0x1234 then 0xABCD, `word_count`=2, `done_loading`=1, `error`=0. With the macro defined, also send `BE 01`.
- **Checksum mismatch (macro defined):** same frame but checksum `00 00`. Required: `error`=1, `done_loading`=0, and exactly 2 words written.
- **Framing error:** send byte 0x12 with its stop bit forced to 0 during W_HI. Required: `error`=1, `rom_loader_load`=0.
- **Overrun:** hold `rom_loader_ack`=0 while 2 more bytes arrive. Required: `error`=1.
- **Empty program:** send N=0 (`00 00`, plus `00 00` checksum if the macro is defined). Required: no sck pulses, `done_loading`=1, `word_count`=0.
- **Reset mid-session:** assert `reset` while in SCK_H. Required: all outputs 0 immediately. Then deassert `reset`, toggle `run`, and resend the frame; the full load must complete.

Source files
------------

// File: rtl/uart_rom_loader.sv
// uart_rom_loader
//   Receives a Hack program over an 8N1 UART line. The program is assembled
//   into 16-bit instructions, and each instruction is written into the hack_soc
//   ROM through a four-phase sck/ack handshake.
//   Session frame (big-endian): LEN_HI LEN_LO, N x (W_HI W_LO) [, CS_HI CS_LO].
//
//   Optional feature macro: UART_ROM_LOADER_CHECKSUM_EN
//     When it is defined, a 16-bit checksum (the sum of all words, mod 2^16)
//     follows the words and is verified before done_loading asserts.
//
// Ports
//   clk             system clock
//   reset           asynchronous active-high reset, clears all state
//   run             level; starts a session from IDLE, and dropping it leaves DONE
//   uart_rx         serial input, idles high
//   rom_loader_load high from the first data word until DONE/ERROR
//   rom_loader_sck  write strobe for the handshake
//   rom_loader_data instruction word, held stable while sck/ack are high
//   rom_loader_ack  handshake acknowledge from hack_soc
//   done_loading    high in DONE
//   error           high in ERROR (sticky until reset)
//   word_count      words written in this session
module uart_rom_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  uart_rx,
  output logic                  rom_loader_load,
  output logic                  rom_loader_sck,
  output logic [DATA_WIDTH-1:0] rom_loader_data,
  input  logic                  rom_loader_ack,
  output logic                  done_loading,
  output logic                  error,
  output logic [15:0]           word_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state;
  logic          rx_s1, rx_s2, rx_last;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_valid;
  logic          frame_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_last   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= uart_rx;
      rx_s2     <= rx_s1;
      rx_last   <= rx_s2;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          // A level check is not enough: after a framing error, the line can
          // still be low, so a true falling edge is required.
          if (!rx_s2 && rx_last) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_idx <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_idx   <= rx_idx + 1'b1;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt    <= '0;
            rx_state  <= RX_IDLE;
            rx_valid  <= rx_s2;
            frame_err <= !rx_s2;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM state and byte buffer
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, W_HI, W_LO, SCK_H, SCK_L, CS_HI, CS_LO, DONE, ERROR
  } state_t;

  state_t     state;
  logic       buf_full;
  logic [7:0] buf_byte;
  logic       consuming;
  logic       outside;
  logic       buf_take;
  logic       overrun;
  logic       ack_r;

  always_comb begin
    consuming = 1'b0;
    outside   = 1'b0;
    case (state)
      LEN_HI, LEN_LO, W_HI, W_LO, CS_HI, CS_LO: consuming = 1'b1;
      IDLE, DONE, ERROR:                        outside   = 1'b1;
      default: ;
    endcase
  end

  // Outside a session, a buffered byte is taken and dropped. During the
  // handshake, it is held until the FSM returns to W_HI.
  assign buf_take = buf_full && (consuming || outside);
  assign overrun  = rx_valid && buf_full && !buf_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_byte <= '0;
    end else if (rx_valid) begin
      buf_full <= 1'b1;
      buf_byte <= rx_shift;
    end else if (buf_take) begin
      buf_full <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [7:0]  word_hi;
  logic [15:0] next_count;

  assign next_count = word_count + 16'd1;

`ifdef UART_ROM_LOADER_CHECKSUM_EN
  logic [15:0] csum;
  logic [7:0]  cs_hi;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      ack_r           <= 1'b0;
      len_hi          <= '0;
      len             <= '0;
      word_hi         <= '0;
      rom_loader_load <= 1'b0;
      rom_loader_sck  <= 1'b0;
      rom_loader_data <= '0;
      done_loading    <= 1'b0;
      error           <= 1'b0;
      word_count      <= '0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      csum            <= '0;
      cs_hi           <= '0;
`endif
    end else begin
      ack_r <= rom_loader_ack;
      case (state)
        IDLE: begin
          if (run) begin
            state <= LEN_HI;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        LEN_HI: begin
          if (buf_full) begin
            len_hi <= buf_byte;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (buf_full) begin
            len <= {len_hi, buf_byte};
            if ({len_hi, buf_byte} != 16'd0) begin
              state <= W_HI;
            end else begin
`ifdef UART_ROM_LOADER_CHECKSUM_EN
              state <= CS_HI;
`else
              state        <= DONE;
              done_loading <= 1'b1;
`endif
            end
          end
        end
        W_HI: begin
          if (buf_full) begin
            word_hi <= buf_byte;
            state   <= W_LO;
          end
        end
        W_LO: begin
          if (buf_full) begin
            rom_loader_data <= DATA_WIDTH'({word_hi, buf_byte});
            rom_loader_sck  <= 1'b1;
            rom_loader_load <= 1'b1;
            state           <= SCK_H;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
            csum            <= csum + {word_hi, buf_byte};
`endif
          end
        end
        SCK_H: begin
          if (ack_r) begin
            rom_loader_sck <= 1'b0;
            state          <= SCK_L;
          end
        end
        SCK_L: begin
          if (!ack_r) begin
            word_count <= next_count;
            if (next_count != len) begin
              state <= W_HI;
            end else begin
`ifdef UART_ROM_LOADER_CHECKSUM_EN
              state <= CS_HI;
`else
              state           <= DONE;
              rom_loader_load <= 1'b0;
              done_loading    <= 1'b1;
`endif
            end
          end
        end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        CS_HI: begin
          if (buf_full) begin
            cs_hi <= buf_byte;
            state <= CS_LO;
          end
        end
        CS_LO: begin
          if (buf_full) begin
            rom_loader_load <= 1'b0;
            if ({cs_hi, buf_byte} == csum) begin
              state        <= DONE;
              done_loading <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          if (!run) begin
            state        <= IDLE;
            done_loading <= 1'b0;
            word_count   <= '0;
          end
        end
        ERROR: ;
        default: state <= IDLE;
      endcase

      // A receiver fault during a session overrides the transition above.
      if (!outside && (frame_err || overrun)) begin
        state           <= ERROR;
        error           <= 1'b1;
        rom_loader_load <= 1'b0;
        rom_loader_sck  <= 1'b0;
        done_loading    <= 1'b0;
      end
    end
  end

endmodule
